// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Pipeline register between decode/register-read and execute of the 32-bit
//   core. Captures decoded control and operands every cycle, bypasses same-cycle
//   writeback data, inserts a bubble on a load-use hazard, squashes on an
//   EX-resolved taken branch, holds while memory stalls, and counts bubbles.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   D_valid                        decode slot holds a real instruction
//   D_ra, D_rb, D_rd               source / destination register indices
//   D_a, D_b                       ALU operands (PC / offset already muxed)
//   D_a2, D_b2                     raw register values of ra / rb
//   D_ld, D_str, D_brn, D_addi     decoded instruction class
//   D_we, D_op                     register write enable, ALU opcode
//   WB_we, WB_rd, WB_data_mem      writeback port (same cycle as regfile write)
//   EX_flush                       taken branch resolved in EX this cycle
//   M_stall                        memory stage cannot accept; hold EX
//   D_stall                        hold fetch/decode this cycle (combinational)
//   EX_*                           registered decode fields after bypass
//   bubble_cnt                     saturating count of load-use bubbles
//
// Valid/hold semantics: EX_valid qualifies the EX_* bundle. Decode advances into
// EX on every edge where D_stall is low; when D_stall is high the upstream stage
// must present the same instruction again on the next cycle. A flushed decode
// slot is dropped (D_stall stays low), never replayed.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int OP_W      = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic [XLEN-1:0]      D_a,
    input  logic [XLEN-1:0]      D_b,
    input  logic [XLEN-1:0]      D_a2,
    input  logic [XLEN-1:0]      D_b2,
    input  logic                 D_ld,
    input  logic                 D_str,
    input  logic                 D_brn,
    input  logic                 D_addi,
    input  logic                 D_we,
    input  logic [OP_W-1:0]      D_op,
    input  logic                 WB_we,
    input  logic [ADDR_SIZE-1:0] WB_rd,
    input  logic [XLEN-1:0]      WB_data_mem,
    input  logic                 EX_flush,
    input  logic                 M_stall,
    output logic                 D_stall,
    output logic                 EX_valid,
    output logic [ADDR_SIZE-1:0] EX_ra,
    output logic [ADDR_SIZE-1:0] EX_rb,
    output logic [ADDR_SIZE-1:0] EX_rd,
    output logic [XLEN-1:0]      EX_a,
    output logic [XLEN-1:0]      EX_b,
    output logic [XLEN-1:0]      EX_a2,
    output logic [XLEN-1:0]      EX_b2,
    output logic                 EX_ld,
    output logic                 EX_str,
    output logic                 EX_brn,
    output logic                 EX_addi,
    output logic                 EX_we,
    output logic [OP_W-1:0]      EX_op,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic            uses_rb;
    logic            load_use;
    logic            byp_a;
    logic            byp_b;
    logic [XLEN-1:0] nx_a;
    logic [XLEN-1:0] nx_b;
    logic [XLEN-1:0] nx_a2;
    logic [XLEN-1:0] nx_b2;

    // Loads and addi take their second operand from the immediate, so rb is
    // not a true source for them.
    assign uses_rb  = !(D_ld || D_addi);
    assign load_use = D_valid && EX_valid && EX_ld && (EX_rd != '0) &&
                      ((D_ra == EX_rd) || (uses_rb && (D_rb == EX_rd)));

    // A flush discards the decode slot, so a hazard against it must not stall.
    assign D_stall  = M_stall || (load_use && !EX_flush);

    // The regfile writes on the same edge we capture, so its read port still
    // shows the old value; take the writeback data directly.
    assign byp_a = WB_we && (WB_rd != '0) && (WB_rd == D_ra);
    assign byp_b = WB_we && (WB_rd != '0) && (WB_rd == D_rb);

    // Branches carry PC in operand A; memory ops and addi carry the offset in B.
    assign nx_a2 = byp_a ? WB_data_mem : D_a2;
    assign nx_b2 = byp_b ? WB_data_mem : D_b2;
    assign nx_a  = (byp_a && !D_brn) ? WB_data_mem : D_a;
    assign nx_b  = (byp_b && !(D_ld || D_str || D_brn || D_addi)) ? WB_data_mem : D_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_valid   <= 1'b0;
            EX_ra      <= '0;
            EX_rb      <= '0;
            EX_rd      <= '0;
            EX_a       <= '0;
            EX_b       <= '0;
            EX_a2      <= '0;
            EX_b2      <= '0;
            EX_ld      <= 1'b0;
            EX_str     <= 1'b0;
            EX_brn     <= 1'b0;
            EX_addi    <= 1'b0;
            EX_we      <= 1'b0;
            EX_op      <= '0;
            bubble_cnt <= '0;
        end else if (M_stall) begin
            // Hold everything; a pending flush is re-asserted by the branch
            // still sitting in EX once the stall clears.
        end else if (EX_flush || load_use || !D_valid) begin
            // Bubble: every field zero so nothing downstream has side effects.
            EX_valid <= 1'b0;
            EX_ra    <= '0;
            EX_rb    <= '0;
            EX_rd    <= '0;
            EX_a     <= '0;
            EX_b     <= '0;
            EX_a2    <= '0;
            EX_b2    <= '0;
            EX_ld    <= 1'b0;
            EX_str   <= 1'b0;
            EX_brn   <= 1'b0;
            EX_addi  <= 1'b0;
            EX_we    <= 1'b0;
            EX_op    <= '0;
            if (!EX_flush && load_use && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            EX_valid <= 1'b1;
            EX_ra    <= D_ra;
            EX_rb    <= D_rb;
            EX_rd    <= D_rd;
            EX_a     <= nx_a;
            EX_b     <= nx_b;
            EX_a2    <= nx_a2;
            EX_b2    <= nx_b2;
            EX_ld    <= D_ld;
            EX_str   <= D_str;
            EX_brn   <= D_brn;
            EX_addi  <= D_addi;
            EX_we    <= D_we;
            EX_op    <= D_op;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int V_W = 1 + 3 * 5 + 4 * 32 + 5 + 4 + 16;

  logic        clk;
  logic        rst_n;
  logic        D_valid;
  logic [4:0]  D_ra, D_rb, D_rd;
  logic [31:0] D_a, D_b, D_a2, D_b2;
  logic        D_ld, D_str, D_brn, D_addi, D_we;
  logic [3:0]  D_op;
  logic        WB_we;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data_mem;
  logic        EX_flush, M_stall;
  logic        D_stall, EX_valid;
  logic [4:0]  EX_ra, EX_rb, EX_rd;
  logic [31:0] EX_a, EX_b, EX_a2, EX_b2;
  logic        EX_ld, EX_str, EX_brn, EX_addi, EX_we;
  logic [3:0]  EX_op;
  logic [15:0] bubble_cnt;

  logic [V_W-1:0] exp_q[$];
  string          name_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid),
    .D_ra(D_ra), .D_rb(D_rb), .D_rd(D_rd),
    .D_a(D_a), .D_b(D_b), .D_a2(D_a2), .D_b2(D_b2),
    .D_ld(D_ld), .D_str(D_str), .D_brn(D_brn), .D_addi(D_addi), .D_we(D_we),
    .D_op(D_op), .WB_we(WB_we), .WB_rd(WB_rd), .WB_data_mem(WB_data_mem),
    .EX_flush(EX_flush), .M_stall(M_stall), .D_stall(D_stall),
    .EX_valid(EX_valid), .EX_ra(EX_ra), .EX_rb(EX_rb), .EX_rd(EX_rd),
    .EX_a(EX_a), .EX_b(EX_b), .EX_a2(EX_a2), .EX_b2(EX_b2),
    .EX_ld(EX_ld), .EX_str(EX_str), .EX_brn(EX_brn), .EX_addi(EX_addi),
    .EX_we(EX_we), .EX_op(EX_op), .bubble_cnt(bubble_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [V_W-1:0] dut_vec();
    return {EX_valid, EX_ra, EX_rb, EX_rd, EX_a, EX_b, EX_a2, EX_b2,
            EX_ld, EX_str, EX_brn, EX_addi, EX_we, EX_op, bubble_cnt};
  endfunction

  function automatic logic [V_W-1:0] mk(
    input logic v, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] a2, input logic [31:0] b2,
    input logic ld, input logic str, input logic brn, input logic addi, input logic we,
    input logic [3:0] op, input logic [15:0] bc);
    return {v, ra, rb, rd, a, b, a2, b2, ld, str, brn, addi, we, op, bc};
  endfunction

  function automatic logic [V_W-1:0] bubble(input logic [15:0] bc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bc);
  endfunction

  // driver tasks
  task automatic drive(
    input logic v, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] a2, input logic [31:0] b2,
    input logic ld, input logic str, input logic brn, input logic addi, input logic we,
    input logic [3:0] op);
    D_valid = v; D_ra = ra; D_rb = rb; D_rd = rd;
    D_a = a; D_b = b; D_a2 = a2; D_b2 = b2;
    D_ld = ld; D_str = str; D_brn = brn; D_addi = addi; D_we = we; D_op = op;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    WB_we = we; WB_rd = rd; WB_data_mem = d;
  endtask

  // Check the combinational stall, then clock one edge and queue the
  // expected registered state for the monitor.
  task automatic step(input string name, input logic exp_stall, input logic [V_W-1:0] exp);
    #1;
    n_tests++;
    if (D_stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s_stall: D_stall=%b expected %b", name, D_stall, exp_stall);
    end
    @(posedge clk);
    exp_q.push_back(exp);
    name_q.push_back(name);
    #2;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [V_W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (dut_vec() !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, dut_vec(), e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    EX_flush = 1'b0;
    M_stall  = 1'b0;
    #2;
    n_tests++;
    if (dut_vec() !== '0 || D_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: got %h stall %b expected 0", dut_vec(), D_stall);
    end
    #11 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // pass-through
    drive(1, 3, 1, 7, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0, 1, 5);
    step("pass", 0, mk(1, 3, 1, 7, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0, 1, 5, 0));

    // WB bypass on both sources
    drive(1, 4, 4, 8, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0, 0, 1, 2);
    wb(1, 4, 32'hDEAD);
    step("byp_both", 0, mk(1, 4, 4, 8, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 0, 0, 0, 0, 1, 2, 0));

    // store keeps its offset in EX_b
    drive(1, 4, 4, 8, 32'h1, 32'h7, 32'h3, 32'h4, 0, 1, 0, 0, 0, 2);
    step("byp_str", 0, mk(1, 4, 4, 8, 32'hDEAD, 32'h7, 32'hDEAD, 32'hDEAD, 0, 1, 0, 0, 0, 2, 0));

    // writeback to r0 never bypasses
    drive(1, 4, 4, 8, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0, 0, 1, 2);
    wb(1, 0, 32'hDEAD);
    step("byp_r0", 0, mk(1, 4, 4, 8, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0, 0, 1, 2, 0));

    // branch keeps PC in EX_a, raw value bypassed
    drive(1, 4, 9, 0, 32'h100, 32'h2, 32'h3, 32'h4, 0, 0, 1, 0, 0, 3);
    wb(1, 4, 32'hBEEF);
    step("byp_brn", 0, mk(1, 4, 9, 0, 32'h100, 32'h2, 32'hBEEF, 32'h4, 0, 0, 1, 0, 0, 3, 0));
    wb(0, 0, 0);

    // load then dependent add: one bubble, then add captures
    drive(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0);
    step("load1", 0, mk(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0, 0));
    drive(1, 6, 1, 9, 32'h5, 32'h6, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1);
    step("lu_bubble", 1, bubble(1));
    step("lu_add", 0, mk(1, 6, 1, 9, 32'h5, 32'h6, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1, 1));

    // addi with rb matching load rd does not stall
    drive(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0);
    step("load2", 0, mk(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0, 1));
    drive(1, 2, 6, 3, 32'h10, 32'h20, 32'h10, 32'h30, 0, 0, 0, 1, 1, 0);
    step("addi_nostall", 0, mk(1, 2, 6, 3, 32'h10, 32'h20, 32'h10, 32'h30, 0, 0, 0, 1, 1, 0, 1));

    // flush beats load-use: no stall, no count
    drive(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0);
    step("load3", 0, mk(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0, 1));
    drive(1, 6, 1, 9, 32'h5, 32'h6, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1);
    EX_flush = 1'b1;
    step("flush_lu", 0, bubble(1));
    EX_flush = 1'b0;

    // load to r0 never stalls
    drive(1, 0, 0, 0, 32'h50, 32'h4, 32'h50, 32'h0, 1, 0, 0, 0, 0, 0);
    step("load_r0", 0, mk(1, 0, 0, 0, 32'h50, 32'h4, 32'h50, 32'h0, 1, 0, 0, 0, 0, 0, 1));
    drive(1, 0, 0, 5, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1);
    step("r0_nostall", 0, mk(1, 0, 0, 5, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 1));

    // memory stall freezes EX despite flush
    drive(1, 1, 2, 0, 32'h200, 32'h10, 32'hA, 32'hB, 0, 0, 1, 0, 0, 3);
    step("brn", 0, mk(1, 1, 2, 0, 32'h200, 32'h10, 32'hA, 32'hB, 0, 0, 1, 0, 0, 3, 1));
    drive(1, 5, 5, 5, 32'h9, 32'h9, 32'h9, 32'h9, 0, 0, 0, 0, 1, 7);
    M_stall  = 1'b1;
    EX_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("mstall", 1, mk(1, 1, 2, 0, 32'h200, 32'h10, 32'hA, 32'hB, 0, 0, 1, 0, 0, 3, 1));
    end
    M_stall = 1'b0;
    step("mstall_rel", 0, bubble(1));
    EX_flush = 1'b0;

    // invalid decode slot captures as a clean bubble
    drive(0, 3, 3, 3, 32'h77, 32'h77, 32'h77, 32'h77, 1, 1, 1, 0, 1, 4);
    step("dinvalid", 0, bubble(1));

    // hazard through rb, second bubble
    drive(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0);
    step("load4", 0, mk(1, 2, 0, 6, 32'h40, 32'h8, 32'h40, 32'h0, 1, 0, 0, 0, 1, 0, 1));
    drive(1, 1, 6, 9, 32'h5, 32'h6, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1);
    step("lu_rb", 1, bubble(2));
    step("lu_rb_add", 0, mk(1, 1, 6, 9, 32'h5, 32'h6, 32'h5, 32'h6, 0, 0, 0, 0, 1, 1, 2));

    // asynchronous reset mid-stream
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== '0 || D_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h stall %b expected 0", dut_vec(), D_stall);
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
